// File: rtl/us_scan_sequencer_if.sv
// Bundle between the scan sequencer and its controller: run controls in,
// transducer drive, depth markers and scan angle out.
interface us_scan_sequencer_if #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int ANG_W = 8
);
  logic             on;
  logic             mode;
  logic             transmit;
  logic [N_CH-1:0]  tx_en;
  logic             receive;
  logic             z_on;
  logic             marker;
  logic [CH_W-1:0]  channel;
  logic [ANG_W-1:0] angle;
  logic             increment;
  logic             frame_done;

  modport master (
    output on, mode,
    input  transmit, tx_en, receive, z_on, marker, channel, angle, increment, frame_done
  );

  modport slave (
    input  on, mode,
    output transmit, tx_en, receive, z_on, marker, channel, angle, increment, frame_done
  );
endinterface

// File: rtl/us_scan_sequencer.sv
// Pulse-echo scan sequencer: WAIT -> TX -> RX shots round-robin over N_CH channels,
// with per-cm depth markers, Z gating and a per-frame wrap/bounce scan angle.
module us_scan_sequencer #(
  parameter int CNT_W   = 16,
  parameter int T_WAIT  = 20000,
  parameter int T_TX    = 50,
  parameter int T_RX    = 2000,
  parameter int CM_CYC  = 65,
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int ANG_W   = 8,
  parameter int ANG_MAX = 90
) (
  input  logic                clock,
  input  logic                clrn,
  us_scan_sequencer_if.slave  bus
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_TX   = 2'd1;
  localparam logic [1:0] S_RX   = 2'd2;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(T_WAIT - 1);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(T_TX - 1);
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(T_RX - 1);
  localparam logic [CNT_W-1:0] CM_LAST   = CNT_W'(CM_CYC - 1);
  localparam logic [CNT_W-1:0] CM_LIM    = CNT_W'(CM_CYC);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);
  localparam logic [ANG_W-1:0] ANG_TOP   = ANG_W'(ANG_MAX);
  localparam logic [ANG_W-1:0] ANG_ONE   = ANG_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cm_cnt;
  logic [CH_W-1:0]  channel;
  logic [ANG_W-1:0] angle;
  logic             dir_down;
  logic             increment_q;

  logic             state_last;
  logic             frame_end;
  logic [ANG_W-1:0] angle_nxt;
  logic             dir_nxt;

  always_comb begin
    state_last = 1'b0;
    case (state)
      S_WAIT:  state_last = (cnt == WAIT_LAST);
      S_TX:    state_last = (cnt == TX_LAST);
      S_RX:    state_last = (cnt == RX_LAST);
      default: state_last = 1'b1;
    endcase
  end

  assign frame_end = (state == S_RX) && state_last && (channel == CH_LAST);

  // Bounce mode also recovers from an out-of-step dir (e.g. after a wrap-mode
  // frame left angle at the top), so the angle can never leave 0..ANG_MAX.
  always_comb begin
    angle_nxt = angle;
    dir_nxt   = dir_down;
    if (!bus.mode) begin
      dir_nxt   = 1'b0;
      angle_nxt = (angle >= ANG_TOP) ? '0 : angle + ANG_ONE;
    end else if (!dir_down) begin
      if (angle >= ANG_TOP) begin
        angle_nxt = ANG_TOP - ANG_ONE;
        dir_nxt   = (ANG_TOP != ANG_ONE);
      end else begin
        angle_nxt = angle + ANG_ONE;
        dir_nxt   = ((angle + ANG_ONE) == ANG_TOP);
      end
    end else begin
      if (angle == '0) begin
        angle_nxt = ANG_ONE;
        dir_nxt   = (ANG_ONE == ANG_TOP);
      end else begin
        angle_nxt = angle - ANG_ONE;
        dir_nxt   = (angle != ANG_ONE);
      end
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state       <= S_WAIT;
      cnt         <= '0;
      cm_cnt      <= '0;
      channel     <= '0;
      angle       <= '0;
      dir_down    <= 1'b0;
      increment_q <= 1'b0;
    end else if (bus.on) begin
      increment_q <= frame_end;
      if (state_last) begin
        cnt    <= '0;
        cm_cnt <= '0;
        case (state)
          S_WAIT:  state <= S_TX;
          S_TX:    state <= S_RX;
          default: state <= S_WAIT;
        endcase
        if (state == S_RX) begin
          channel <= (channel == CH_LAST) ? '0 : channel + CH_W'(1);
        end
        if (frame_end) begin
          angle    <= angle_nxt;
          dir_down <= dir_nxt;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (state == S_RX) begin
          cm_cnt <= (cm_cnt == CM_LAST) ? '0 : cm_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Outputs come only from registers; on gates them so a paused scan is silent.
  always_comb begin
    bus.tx_en = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.tx_en[i] = bus.on && (state == S_TX) && (channel == CH_W'(i));
    end
  end

  assign bus.transmit   = bus.on && (state == S_TX);
  assign bus.receive    = bus.on && (state == S_RX);
  assign bus.z_on       = bus.on && (state == S_RX) && (cnt >= CM_LIM);
  assign bus.marker     = bus.on && (state == S_RX) && (cm_cnt == '0) && (cnt != '0);
  assign bus.channel    = bus.on ? channel : '0;
  assign bus.angle      = bus.on ? angle : '0;
  assign bus.increment  = bus.on && increment_q;
  assign bus.frame_done = bus.on && frame_end;

endmodule
